// File: rtl/fx3_pkg.sv
// Shared types and constants for the FX3 GPIF-II slave-FIFO write path.
package fx3_pkg;

  localparam int unsigned GPIF_DW          = 16;
  localparam int unsigned GPIF_AW          = 2;
  localparam int unsigned DEF_BURST_LEN    = 256;
  localparam int unsigned DEF_FLAG_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    PKTEND = 2'd2,
    GUARD  = 2'd3
  } state_e;

endpackage

// File: rtl/fx3_gpif_tx.sv
// Streams 16-bit words into an FX3 socket in full-buffer bursts, committing
// short packets with PKTEND when the upstream source stalls mid-burst.
module fx3_gpif_tx
  import fx3_pkg::*;
#(
  parameter int unsigned          BURST_LEN    = DEF_BURST_LEN,
  parameter int unsigned          FLAG_LATENCY = DEF_FLAG_LATENCY,
  parameter int unsigned          IDLE_TIMEOUT = 64,
  parameter logic [GPIF_AW-1:0]   SOCKET       = 2'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [GPIF_DW-1:0] s_data_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  output logic [GPIF_DW-1:0] fx3_data_o,
  output logic               fx3_data_oe_o,
  output logic               fx3_slwr_n_o,
  output logic               fx3_pktend_n_o,
  output logic [GPIF_AW-1:0] fx3_addr_o,
  input  logic               fx3_flag_i
);

  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  localparam int unsigned SW = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned GW = $clog2(FLAG_LATENCY + 1);

  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(IDLE_TIMEOUT - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(FLAG_LATENCY - 1);

  state_e               state_q, state_d;
  logic                 flag_q;
  logic [BW-1:0]        burst_cnt_q, burst_cnt_d;
  logic [SW-1:0]        stall_cnt_q, stall_cnt_d;
  logic [GW-1:0]        guard_cnt_q, guard_cnt_d;
  logic                 slwr_n_q, slwr_n_d;
  logic                 pktend_n_q, pktend_n_d;
  logic                 oe_q, oe_d;
  logic [GPIF_DW-1:0]   data_q, data_d;
  logic                 accept;

  assign s_ready_o = (state_q == WRITE);
  assign accept    = s_valid_i & s_ready_o;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    stall_cnt_d = stall_cnt_q;
    guard_cnt_d = guard_cnt_q;

    case (state_q)
      IDLE: begin
        if (flag_q) state_d = WRITE;
      end
      WRITE: begin
        if (accept) begin
          stall_cnt_d = '0;
          if (burst_cnt_q == BURST_LAST) begin
            burst_cnt_d = '0;
            state_d     = GUARD;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else if (burst_cnt_q != '0) begin
          // An empty burst may wait forever; only a partial one gets flushed.
          if (stall_cnt_q == STALL_LAST) begin
            burst_cnt_d = '0;
            stall_cnt_d = '0;
            state_d     = PKTEND;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
      end
      PKTEND: begin
        state_d = GUARD;
      end
      GUARD: begin
        if (guard_cnt_q == GUARD_LAST) begin
          guard_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    slwr_n_d   = ~accept;
    data_d     = accept ? s_data_i : data_q;
    pktend_n_d = (state_d != PKTEND);
    // Keep the bus driven through the strobe of the final word, which lands in GUARD.
    oe_d       = (state_d == WRITE) || (state_d == PKTEND) || accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flag_q      <= 1'b0;
      burst_cnt_q <= '0;
      stall_cnt_q <= '0;
      guard_cnt_q <= '0;
      slwr_n_q    <= 1'b1;
      pktend_n_q  <= 1'b1;
      oe_q        <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      flag_q      <= fx3_flag_i;
      burst_cnt_q <= burst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      slwr_n_q    <= slwr_n_d;
      pktend_n_q  <= pktend_n_d;
      oe_q        <= oe_d;
      data_q      <= data_d;
    end
  end

  assign fx3_data_o     = data_q;
  assign fx3_data_oe_o  = oe_q;
  assign fx3_slwr_n_o   = slwr_n_q;
  assign fx3_pktend_n_o = pktend_n_q;
  assign fx3_addr_o     = SOCKET;

endmodule

// File: tb/tb_fx3_gpif_tx.sv
// Directed bench for fx3_gpif_tx with BURST_LEN=8, FLAG_LATENCY=4, IDLE_TIMEOUT=16.
module tb_fx3_gpif_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [15:0] fx3_data_o;
  logic        fx3_data_oe_o;
  logic        fx3_slwr_n_o;
  logic        fx3_pktend_n_o;
  logic [1:0]  fx3_addr_o;
  logic        fx3_flag_i;

  fx3_gpif_tx #(
    .BURST_LEN    (8),
    .FLAG_LATENCY (4),
    .IDLE_TIMEOUT (16),
    .SOCKET       (2'd0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_data_i       (s_data_i),
    .s_valid_i      (s_valid_i),
    .s_ready_o      (s_ready_o),
    .fx3_data_o     (fx3_data_o),
    .fx3_data_oe_o  (fx3_data_oe_o),
    .fx3_slwr_n_o   (fx3_slwr_n_o),
    .fx3_pktend_n_o (fx3_pktend_n_o),
    .fx3_addr_o     (fx3_addr_o),
    .fx3_flag_i     (fx3_flag_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          acc     = 0;
  logic        hs      = 1'b0;
  logic [15:0] next_word;

  // Passive GPIF monitor: logs every strobe and PKTEND seen at the falling edge.
  logic [15:0] wr_data [256];
  int          wr_t    [256];
  int          wr_n    = 0;
  int          pk_n    = 0;
  int          cyc     = 0;
  int          oe_bad  = 0;
  int          pk_bad  = 0;

  always @(negedge clk) begin
    if (!fx3_slwr_n_o) begin
      if (wr_n < 256) begin
        wr_data[wr_n] = fx3_data_o;
        wr_t[wr_n]    = cyc;
      end
      wr_n++;
      if (!fx3_data_oe_o) oe_bad++;
    end
    if (!fx3_pktend_n_o) begin
      pk_n++;
      if (!fx3_slwr_n_o || !fx3_data_oe_o) pk_bad++;
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    hs = s_valid_i && s_ready_o;
    @(posedge clk);
    #1;
    if (hs) begin
      acc++;
      next_word = next_word + 16'd1;
      s_data_i  = next_word;
    end
  endtask

  task automatic run_acc(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (acc < target && n < budget) begin
      cycle();
      n++;
    end
    check(tag, acc, target);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    s_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    next_word = 16'd1;
    s_data_i  = 16'd1;
    acc       = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, base2, pk0, k;
    rst_n      = 1'b0;
    s_valid_i  = 1'b0;
    s_data_i   = 16'd0;
    fx3_flag_i = 1'b0;
    next_word  = 16'd1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_slwr_n",   fx3_slwr_n_o,   1);
    check("rst_pktend_n", fx3_pktend_n_o, 1);
    check("rst_oe",       fx3_data_oe_o,  0);
    check("rst_data",     fx3_data_o,     0);
    check("rst_ready",    s_ready_o,      0);
    check("rst_addr",     fx3_addr_o,     0);

    // Full back-to-back burst
    fx3_flag_i = 1'b1;
    do_reset();
    base = wr_n; pk0 = pk_n;
    s_valid_i = 1'b1;
    run_acc("t1_accepts", 8, 50);
    for (int i = 0; i < 4; i++) begin
      check("t1_ready_guard", s_ready_o, 0);
      cycle();
    end
    s_valid_i = 1'b0;
    check("t1_ready_idle", s_ready_o, 0);
    cycle();
    check("t1_ready_back", s_ready_o, 1);
    check("t1_strobes", wr_n - base, 8);
    for (int i = 0; i < 8; i++) check("t1_data", wr_data[base + i], i + 1);
    check("t1_contiguous", wr_t[base + 7] - wr_t[base], 7);
    check("t1_no_pktend", pk_n - pk0, 0);

    // Flag low blocks writes; raising it gives the first strobe 3 cycles later
    fx3_flag_i = 1'b0;
    do_reset();
    base = wr_n;
    s_valid_i = 1'b1;
    repeat (6) cycle();
    check("t2_ready_blocked", s_ready_o, 0);
    check("t2_no_strobe", wr_n - base, 0);
    fx3_flag_i = 1'b1;
    k = 0;
    while (k < 10) begin
      cycle();
      k++;
      if (!fx3_slwr_n_o) break;
    end
    check("t2_first_strobe_lat", k, 3);
    check("t2_first_data", fx3_data_o, 16'h0001);
    s_valid_i = 1'b0;

    // Stall timeout commits a short packet, then a fresh burst starts from zero
    do_reset();
    base = wr_n; pk0 = pk_n;
    s_valid_i = 1'b1;
    run_acc("t3_accepts", 3, 40);
    s_valid_i = 1'b0;
    k = 0;
    while (k < 40) begin
      cycle();
      k++;
      if (!fx3_pktend_n_o) break;
    end
    check("t3_pktend_delay", k, 16);
    check("t3_pktend_slwr_n", fx3_slwr_n_o, 1);
    check("t3_pktend_oe", fx3_data_oe_o, 1);
    cycle();
    check("t3_pktend_one_cycle", fx3_pktend_n_o, 1);
    s_valid_i = 1'b1;
    base2 = wr_n;
    run_acc("t3_next_burst", 11, 60);
    check("t3_ready_after_burst", s_ready_o, 0);
    s_valid_i = 1'b0;
    cycle();
    check("t3_strobes_after", wr_n - base2, 8);
    check("t3_first_after", wr_data[base2], 16'h0004);
    check("t3_last_after", wr_data[base2 + 7], 16'h000B);
    check("t3_pktend_count", pk_n - pk0, 1);

    // Bubble shorter than the timeout does not commit
    do_reset();
    base = wr_n; pk0 = pk_n;
    s_valid_i = 1'b1;
    run_acc("t4_accepts_a", 3, 40);
    s_valid_i = 1'b0;
    repeat (10) cycle();
    s_valid_i = 1'b1;
    run_acc("t4_accepts_b", 8, 40);
    check("t4_ready_guard", s_ready_o, 0);
    s_valid_i = 1'b0;
    cycle();
    check("t4_strobes", wr_n - base, 8);
    for (int i = 0; i < 8; i++) check("t4_data", wr_data[base + i], i + 1);
    check("t4_no_pktend", pk_n - pk0, 0);

    // Flag dropping mid-burst: burst completes, then no new burst until flag returns
    do_reset();
    base = wr_n;
    s_valid_i = 1'b1;
    run_acc("t5_accepts_a", 2, 40);
    fx3_flag_i = 1'b0;
    run_acc("t5_accepts_b", 8, 40);
    repeat (20) cycle();
    check("t5_strobes_held", wr_n - base, 8);
    check("t5_ready_held", s_ready_o, 0);
    fx3_flag_i = 1'b1;
    run_acc("t5_resume", 16, 40);
    s_valid_i = 1'b0;
    cycle();
    check("t5_strobes_total", wr_n - base, 16);
    check("t5_resume_first", wr_data[base + 8], 16'h0009);

    // Asynchronous reset mid-burst
    do_reset();
    s_valid_i = 1'b1;
    run_acc("t6_accepts", 4, 40);
    check("t6_strobe_before", fx3_slwr_n_o, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_slwr_n", fx3_slwr_n_o, 1);
    check("t6_async_oe", fx3_data_oe_o, 0);
    check("t6_async_pktend_n", fx3_pktend_n_o, 1);
    s_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    next_word = 16'd1;
    s_data_i  = 16'd1;
    acc       = 0;
    base = wr_n; pk0 = pk_n;
    s_valid_i = 1'b1;
    run_acc("t6_post_accepts", 8, 40);
    s_valid_i = 1'b0;
    cycle();
    check("t6_strobes", wr_n - base, 8);
    for (int i = 0; i < 8; i++) check("t6_data", wr_data[base + i], i + 1);
    check("t6_no_pktend", pk_n - pk0, 0);

    check("oe_during_strobe", oe_bad, 0);
    check("pktend_shape", pk_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
